// File: rtl/voice_mixer_stereo.sv
// Stereo voice mixer: one left/right MAC pair walks the voices of a captured frame, then saturates.
// Optional build macro VOICE_MIXER_AUTO_ATTEN_EN scales the sums down by the count of active voices.
module voice_mixer_stereo #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_VOICES = 16,
    parameter int GAIN_WIDTH = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DATA_WIDTH*NUM_VOICES-1:0] voice_in_flat,
    input  logic [GAIN_WIDTH*NUM_VOICES-1:0] gain_l_flat,
    input  logic [GAIN_WIDTH*NUM_VOICES-1:0] gain_r_flat,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [DATA_WIDTH-1:0]            left_out,
    output logic [DATA_WIDTH-1:0]            right_out,
    output logic                             clip_l,
    output logic                             clip_r,
    output logic                             out_valid,
    input  logic                             out_ready
);
    localparam int ACC_WIDTH = DATA_WIDTH + $clog2(NUM_VOICES) + 2;
    localparam int IDX_W     = $clog2(NUM_VOICES);
    localparam int PROD_W    = DATA_WIDTH + GAIN_WIDTH + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;
    state_t state, state_next;

    logic [DATA_WIDTH*NUM_VOICES-1:0] voice_q;
    logic [GAIN_WIDTH*NUM_VOICES-1:0] gain_l_q, gain_r_q;
    logic [IDX_W-1:0]                 idx;
    logic signed [ACC_WIDTH-1:0]      acc_l, acc_r;

    logic signed [DATA_WIDTH-1:0] voice_k;
    logic [GAIN_WIDTH-1:0]        gain_l_k, gain_r_k;
    logic signed [PROD_W-1:0]     prod_l, prod_r, shr_l, shr_r;
    logic signed [ACC_WIDTH-1:0]  sum_l, sum_r, fin_l, fin_r;

    // Result is {clip, saturated sample}.
    function automatic logic [DATA_WIDTH:0] saturate(input logic signed [ACC_WIDTH-1:0] v);
        if (v > SAT_MAX)      saturate = {1'b1, SAT_MAX[DATA_WIDTH-1:0]};
        else if (v < SAT_MIN) saturate = {1'b1, SAT_MIN[DATA_WIDTH-1:0]};
        else                  saturate = {1'b0, v[DATA_WIDTH-1:0]};
    endfunction

`ifdef VOICE_MIXER_AUTO_ATTEN_EN
    localparam int CNT_W = $clog2(NUM_VOICES + 1);
    logic [CNT_W-1:0] active_cnt, cnt_next;
    int               atten_shift;

    function automatic int ceil_log2(input logic [CNT_W-1:0] n);
        ceil_log2 = 0;
        for (int s = 0; s <= CNT_W; s++)
            if ((64'd1 << s) < 64'(n)) ceil_log2 = s + 1;
    endfunction
`endif

    always_comb begin
        voice_k  = voice_q[int'(idx)*DATA_WIDTH +: DATA_WIDTH];
        gain_l_k = gain_l_q[int'(idx)*GAIN_WIDTH +: GAIN_WIDTH];
        gain_r_k = gain_r_q[int'(idx)*GAIN_WIDTH +: GAIN_WIDTH];
        prod_l   = voice_k * $signed({1'b0, gain_l_k});
        prod_r   = voice_k * $signed({1'b0, gain_r_k});
        // Arithmetic shift floors toward -inf, so -3 at half gain gives -2.
        shr_l    = prod_l >>> (GAIN_WIDTH - 1);
        shr_r    = prod_r >>> (GAIN_WIDTH - 1);
        sum_l    = acc_l + ACC_WIDTH'(shr_l);
        sum_r    = acc_r + ACC_WIDTH'(shr_r);
`ifdef VOICE_MIXER_AUTO_ATTEN_EN
        cnt_next    = active_cnt + CNT_W'((|gain_l_k) || (|gain_r_k));
        atten_shift = ceil_log2(cnt_next);
        fin_l       = sum_l >>> atten_shift;
        fin_r       = sum_r >>> atten_shift;
`else
        fin_l       = sum_l;
        fin_r       = sum_r;
`endif
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = ACCUM;
            end
            ACCUM: begin
                if (idx == LAST_IDX) state_next = OUTPUT;
            end
            OUTPUT: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            voice_q   <= '0;
            gain_l_q  <= '0;
            gain_r_q  <= '0;
            idx       <= '0;
            acc_l     <= '0;
            acc_r     <= '0;
            left_out  <= '0;
            right_out <= '0;
            clip_l    <= 1'b0;
            clip_r    <= 1'b0;
`ifdef VOICE_MIXER_AUTO_ATTEN_EN
            active_cnt <= '0;
`endif
        end else begin
            state <= state_next;
            case (state)
                IDLE: if (in_valid) begin
                    voice_q  <= voice_in_flat;
                    gain_l_q <= gain_l_flat;
                    gain_r_q <= gain_r_flat;
                    idx      <= '0;
                    acc_l    <= '0;
                    acc_r    <= '0;
`ifdef VOICE_MIXER_AUTO_ATTEN_EN
                    active_cnt <= '0;
`endif
                end
                ACCUM: begin
                    acc_l <= sum_l;
                    acc_r <= sum_r;
                    idx   <= idx + 1'b1;
`ifdef VOICE_MIXER_AUTO_ATTEN_EN
                    active_cnt <= cnt_next;
`endif
                    // Saturate only once the last voice is folded in.
                    if (idx == LAST_IDX) begin
                        {clip_l, left_out}  <= saturate(fin_l);
                        {clip_r, right_out} <= saturate(fin_r);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_voice_mixer_stereo.sv
// Directed bench for voice_mixer_stereo (4 voices); a monitor checks every output handshake against a queue.
module tb_voice_mixer_stereo;
    localparam int DW = 32;
    localparam int NV = 4;
    localparam int GW = 16;
    localparam logic [15:0] U = 16'd32768;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW*NV-1:0] voice_in_flat = '0;
    logic [GW*NV-1:0] gain_l_flat = '0, gain_r_flat = '0;
    logic          in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
    logic [DW-1:0] left_out, right_out;
    logic          clip_l, clip_r;

    int n_cmp = 0;
    int n_bad = 0;
    logic [65:0] exp_q[$];

    voice_mixer_stereo #(.DATA_WIDTH(DW), .NUM_VOICES(NV), .GAIN_WIDTH(GW)) dut (
        .clk(clk), .rst(rst), .voice_in_flat(voice_in_flat), .gain_l_flat(gain_l_flat),
        .gain_r_flat(gain_r_flat), .in_valid(in_valid), .in_ready(in_ready),
        .left_out(left_out), .right_out(right_out), .clip_l(clip_l), .clip_r(clip_r),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [65:0] pack(input logic cl, input logic cr,
                                         input logic [31:0] l, input logic [31:0] r);
        return {cl, cr, l, r};
    endfunction

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", pack(clip_l, clip_r, left_out, right_out), 66'h0);
                if (!(clip_l === 1'b0 && clip_r === 1'b0 && left_out === '0 && right_out === '0)) ;
            end else begin
                check("output", pack(clip_l, clip_r, left_out, right_out), exp_q.pop_front());
            end
        end
    end

    // Drives a frame at posedge+1 and returns just after its accepting edge.
    task automatic accept_frame(input logic [127:0] v, input logic [63:0] gl, input logic [63:0] gr);
        int k = 0;
        voice_in_flat = v; gain_l_flat = gl; gain_r_flat = gr; in_valid = 1'b1;
        while (!in_ready && k < 50) begin
            @(posedge clk); #1; k++;
        end
        check("accept_timeout", 66'(k < 50), 66'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        voice_in_flat = {4{32'hdead_beef}}; gain_l_flat = {4{16'hffff}}; gain_r_flat = {4{16'hffff}};
    endtask

    task automatic send(input logic [127:0] v, input logic [63:0] gl, input logic [63:0] gr,
                        input logic [65:0] exp);
        exp_q.push_back(exp);
        accept_frame(v, gl, gr);
    endtask

    task automatic wait_out_valid(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 50) begin
            @(posedge clk); #1; cycles++;
        end
    endtask

    initial begin
        int lat;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", 66'(in_ready), 66'd1);
        check("reset_out_valid", 66'(out_valid), 66'd0);
        check("reset_outputs", pack(clip_l, clip_r, left_out, right_out), 66'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Test 1: unity left, zero right, with latency measurement.
        send({32'd7, -32'sd50, 32'd200, 32'd100}, {4{U}}, 64'h0, pack(0, 0, 32'd257, 32'd0));
        wait_out_valid(lat);
        check("latency", 66'(lat), 66'd4);
        @(posedge clk); #1;

        // Test 2: saturation both directions.
        send({4{32'h7fff_ffff}}, {4{U}}, 64'h0, pack(1, 0, 32'h7fff_ffff, 32'd0));
        send({4{32'h8000_0000}}, {4{U}}, 64'h0, pack(1, 0, 32'h8000_0000, 32'd0));

        // Test 3: floor toward -inf and near-2.0 gain.
        send({32'd5, 32'd5, 32'd5, -32'sd3}, {48'h0, 16'd16384}, 64'h0, pack(0, 0, -32'sd2, 32'd0));
        send({32'd5, 32'd5, 32'd5, 32'd1000}, {48'h0, 16'd65535}, 64'h0, pack(0, 0, 32'd1999, 32'd0));
        send({32'd9, 32'd9, 32'd9, 32'd9}, 64'h0, 64'h0, pack(0, 0, 32'd0, 32'd0));

        // Test 4: backpressure holds the result and blocks a second frame.
        while (exp_q.size() != 0) begin @(posedge clk); #1; end
        out_ready = 1'b0;
        send({32'd40, 32'd30, 32'd20, 32'd10}, {4{U}}, {4{16'd16384}}, pack(0, 0, 32'd100, 32'd50));
        wait_out_valid(lat);
        check("hold_latency", 66'(lat), 66'd4);
        voice_in_flat = {32'd4, 32'd3, 32'd2, 32'd1}; gain_l_flat = {4{U}}; gain_r_flat = {4{U}};
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("hold_out_valid", 66'(out_valid), 66'd1);
            check("hold_in_ready", 66'(in_ready), 66'd0);
            check("hold_outputs", pack(clip_l, clip_r, left_out, right_out), pack(0, 0, 32'd100, 32'd50));
            @(posedge clk); #1;
        end
        exp_q.push_back(pack(0, 0, 32'd10, 32'd10));
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("release_out_valid", 66'(out_valid), 66'd0);
        check("release_in_ready", 66'(in_ready), 66'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("second_frame_taken", 66'(in_ready), 66'd0);
        wait_out_valid(lat);
        @(posedge clk); #1;

        // Test 5: reset during the second ACCUM cycle aborts the frame.
        accept_frame({32'd4000, 32'd3000, 32'd2000, 32'd1000}, {4{U}}, {4{U}});
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_in_ready", 66'(in_ready), 66'd1);
        check("abort_outputs", pack(clip_l, clip_r, left_out, right_out), 66'h0);
        for (int i = 0; i < 6; i++) begin
            check("abort_out_valid", 66'(out_valid), 66'd0);
            @(posedge clk); #1;
        end
        send({32'd4, 32'd3, 32'd2, 32'd1}, {4{U}}, {4{16'd16384}}, pack(0, 0, 32'd10, 32'd4));

        // Test 6: three active voices; attenuation by 4 only in the macro build.
`ifdef VOICE_MIXER_AUTO_ATTEN_EN
        send({32'd5000, 32'd1000, 32'd1000, 32'd1000}, {16'd0, U, U, U}, 64'h0, pack(0, 0, 32'd750, 32'd0));
`else
        send({32'd5000, 32'd1000, 32'd1000, 32'd1000}, {16'd0, U, U, U}, 64'h0, pack(0, 0, 32'd3000, 32'd0));
`endif

        for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin @(posedge clk); #1; end
        check("queue_drained", 66'(exp_q.size()), 66'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
